// File: rtl/state_readout.sv
// -----------------------------------------------------------------------------
// state_readout
//
// Readout stage that follows the gate scheduler. On start it scans the
// state-vector memory from index 0 to DIM-1. For each basis state it reads
// (re, im), forms the probability re^2 + im^2 and streams (index, probability)
// over a valid/ready handshake. During the scan it tracks the most probable
// basis state (strictly greater wins, so ties keep the lower index) and a
// running sum of all probabilities.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a scan (ignored while busy)
//   busy / done             scan in progress / last scan finished
//   mem_rd_en, mem_addr     read request to the state memory
//   mem_dout_r, mem_dout_i  signed Q2.14 amplitude, valid one cycle after a read
//   out_valid, out_ready    stream handshake
//   out_idx, out_prob       beat payload: basis index and Q4.28 probability
//   out_last                marks the beat for index DIM-1
//   argmax_idx/argmax_prob  most probable state seen so far in this scan
//   norm_sum                running sum of out_prob over this scan
// -----------------------------------------------------------------------------
module state_readout #(
  parameter  int N_QUBITS = 4,
  localparam int DIM      = 1 << N_QUBITS,
  localparam int AW       = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [15:0]       mem_dout_r,
  input  logic [15:0]       mem_dout_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_idx,
  output logic [31:0]       out_prob,
  output logic              out_last,
  output logic [AW-1:0]     argmax_idx,
  output logic [31:0]       argmax_prob,
  output logic [AW+31:0]    norm_sum
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAP,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     out_idx_q, out_idx_d;
  logic [31:0]       out_prob_q, out_prob_d;
  logic              out_last_q, out_last_d;
  logic [AW-1:0]     argmax_idx_q, argmax_idx_d;
  logic [31:0]       argmax_prob_q, argmax_prob_d;
  logic [AW+31:0]    norm_sum_q, norm_sum_d;

  // Probability datapath. Each square is at most 2^30, so the signed products
  // fit in 32 bits and their sum (at most 2^31) fits as unsigned 32 bits.
  logic signed [31:0] re_ext, im_ext;
  logic signed [31:0] re_sq, im_sq;
  logic        [31:0] prob_calc;

  always_comb begin
    re_ext    = {{16{mem_dout_r[15]}}, mem_dout_r};
    im_ext    = {{16{mem_dout_i[15]}}, mem_dout_i};
    re_sq     = re_ext * re_ext;
    im_sq     = im_ext * im_ext;
    prob_calc = $unsigned(re_sq) + $unsigned(im_sq);
  end

  // Next-state logic. The status/strobe outputs are derived from state_d so
  // that, once registered, they are valid for exactly the cycles the FSM
  // spends in the corresponding state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    mem_addr_d    = mem_addr_q;
    out_idx_d     = out_idx_q;
    out_prob_d    = out_prob_q;
    out_last_d    = out_last_q;
    argmax_idx_d  = argmax_idx_q;
    argmax_prob_d = argmax_prob_q;
    norm_sum_d    = norm_sum_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d         = '0;
          argmax_idx_d  = '0;
          argmax_prob_d = '0;
          norm_sum_d    = '0;
          state_d       = S_ADDR;
        end
      end

      S_ADDR: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        out_prob_d = prob_calc;
        out_idx_d  = idx_q;
        out_last_d = (idx_q == LAST_IDX);
        if (prob_calc > argmax_prob_q) begin
          argmax_idx_d  = idx_q;
          argmax_prob_d = prob_calc;
        end
        norm_sum_d = norm_sum_q + {{AW{1'b0}}, prob_calc};
        state_d    = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          // Termination is driven by out_last, so idx never wraps.
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_ADDR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_en_d = (state_d == S_ADDR);
    if (state_d == S_ADDR) begin
      mem_addr_d = idx_d;
    end
    busy_d      = (state_d == S_ADDR) || (state_d == S_CAP) || (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_prob_q    <= '0;
      out_last_q    <= 1'b0;
      argmax_idx_q  <= '0;
      argmax_prob_q <= '0;
      norm_sum_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      out_prob_q    <= out_prob_d;
      out_last_q    <= out_last_d;
      argmax_idx_q  <= argmax_idx_d;
      argmax_prob_q <= argmax_prob_d;
      norm_sum_q    <= norm_sum_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_prob    = out_prob_q;
  assign out_last    = out_last_q;
  assign argmax_idx  = argmax_idx_q;
  assign argmax_prob = argmax_prob_q;
  assign norm_sum    = norm_sum_q;

endmodule

// File: tb/tb_state_readout.sv
// -----------------------------------------------------------------------------
// tb_state_readout
//
// Directed bench for state_readout. A behavioural synchronous-read memory
// feeds the DUT; expected beats are pushed to a scoreboard queue when a scan is
// launched and popped as the DUT hands off beats. Cycle numbers count the start
// edge as cycle 0, and a value seen just before edge n is "in cycle n".
// -----------------------------------------------------------------------------
module tb_state_readout;

  localparam int N   = 4;
  localparam int DIM = 1 << N;
  localparam int AW  = N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_dout_r = '0;
  logic [15:0]     mem_dout_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [AW-1:0]   out_idx;
  logic [31:0]     out_prob;
  logic            out_last;
  logic [AW-1:0]   argmax_idx;
  logic [31:0]     argmax_prob;
  logic [AW+31:0]  norm_sum;

  state_readout #(.N_QUBITS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_dout_r  (mem_dout_r),
    .mem_dout_i  (mem_dout_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_prob    (out_prob),
    .out_last    (out_last),
    .argmax_idx  (argmax_idx),
    .argmax_prob (argmax_prob),
    .norm_sum    (norm_sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural state memory: data appears the cycle after the read strobe.
  int mem_r [DIM];
  int mem_i [DIM];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_dout_r <= 16'(mem_r[mem_addr]);
      mem_dout_i <= 16'(mem_i[mem_addr]);
    end
  end

  typedef struct {
    int unsigned idx;
    logic [31:0] prob;
    logic        last;
  } beat_t;

  beat_t          sb_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             start_cyc = 0;
  int             first_valid_lat = -1;
  int unsigned    exp_amax_idx;
  logic [31:0]    exp_amax_prob;
  logic [AW+31:0] exp_norm;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: probability per entry, strict-greater argmax, plain sum.
  task automatic push_expected();
    longint p;
    beat_t  b;
    exp_amax_idx  = 0;
    exp_amax_prob = '0;
    exp_norm      = '0;
    for (int k = 0; k < DIM; k++) begin
      p = longint'(mem_r[k]) * mem_r[k] + longint'(mem_i[k]) * mem_i[k];
      b.idx  = k;
      b.prob = p[31:0];
      b.last = (k == DIM - 1);
      sb_q.push_back(b);
      if (b.prob > exp_amax_prob) begin
        exp_amax_prob = b.prob;
        exp_amax_idx  = k;
      end
      exp_norm = exp_norm + (AW+32)'(b.prob);
    end
  endtask

  task automatic fill(input int re, input int im);
    for (int k = 0; k < DIM; k++) begin
      mem_r[k] = re;
      mem_i[k] = im;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
    first_valid_lat = -1;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("done_clr_after_start", done, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc + 1;
        break;
      end
    end
    check(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_results(input string tag);
    check({tag, "_argmax_idx"},  64'(argmax_idx), 64'(exp_amax_idx));
    check({tag, "_argmax_prob"}, 64'(argmax_prob), 64'(exp_amax_prob));
    check({tag, "_norm_sum"},    64'(norm_sum), 64'(exp_norm));
    check({tag, "_sb_empty"},    64'(sb_q.size()), 64'd0);
    check({tag, "_first_valid"}, 64'(first_valid_lat), 64'd3);
  endtask

  task automatic wait_rd(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (mem_rd_en && (mem_addr == AW'(a))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy, 1'b0);
    check({tag, "_done"},      done, 1'b0);
    check({tag, "_rd_en"},     mem_rd_en, 1'b0);
    check({tag, "_addr"},      64'(mem_addr), 64'd0);
    check({tag, "_valid"},     out_valid, 1'b0);
    check({tag, "_idx"},       64'(out_idx), 64'd0);
    check({tag, "_prob"},      64'(out_prob), 64'd0);
    check({tag, "_last"},      out_last, 1'b0);
    check({tag, "_amax_idx"},  64'(argmax_idx), 64'd0);
    check({tag, "_amax_prob"}, 64'(argmax_prob), 64'd0);
    check({tag, "_norm"},      64'(norm_sum), 64'd0);
  endtask

  // Stream monitor: scoreboard pops on handoff, payload stability while
  // stalled, and no memory reads while a beat is pending.
  bit          prev_stall = 1'b0;
  logic [AW-1:0] held_idx;
  logic [31:0] held_prob;
  logic        held_last;
  beat_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && first_valid_lat < 0) first_valid_lat = cyc - start_cyc + 1;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_idx",   64'(out_idx), 64'(held_idx));
        check("stall_prob",  64'(out_prob), 64'(held_prob));
        check("stall_last",  out_last, held_last);
      end
      if (out_valid) check("no_rd_in_out", mem_rd_en, 1'b0);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          got = sb_q.pop_front();
          check("beat_idx",  64'(out_idx), 64'(got.idx));
          check("beat_prob", 64'(out_prob), 64'(got.prob));
          check("beat_last", out_last, got.last);
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid && !out_ready;
        held_idx   = out_idx;
        held_prob  = out_prob;
        held_last  = out_last;
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // 1: basis state |0000>
    fill(0, 0);
    mem_r[0] = 16384;
    push_expected();
    pulse_start();
    wait_done("t1_done_cycle", 3 * DIM + 1);
    check_results("t1");
    check("t1_amax_prob_exact", 64'(argmax_prob), 64'h1000_0000);
    repeat (5) @(negedge clk);
    check("t1_done_held", done, 1'b1);
    check("t1_busy_low", busy, 1'b0);
    check("t1_norm_held", 64'(norm_sum), 64'h1000_0000);
    check("t1_amax_held", 64'(argmax_idx), 64'd0);
    check("t1_addr_hold", 64'(mem_addr), 64'(DIM - 1));

    // 2: uniform superposition, restarted from done
    fill(4096, 0);
    push_expected();
    pulse_start();
    wait_done("t2_done_cycle", 3 * DIM + 1);
    check_results("t2");
    check("t2_norm_exact", 64'(norm_sum), 64'h1000_0000);

    // 3a / 3b: signed complex entries
    fill(0, 0);
    mem_r[5] = -8192; mem_i[5] = 8192;
    push_expected();
    pulse_start();
    wait_done("t3a_done_cycle", 3 * DIM + 1);
    check_results("t3a");
    check("t3a_amax_prob_exact", 64'(argmax_prob), 64'h0800_0000);

    mem_r[5] = -32768; mem_i[5] = -32768;
    push_expected();
    pulse_start();
    wait_done("t3b_done_cycle", 3 * DIM + 1);
    check_results("t3b");
    check("t3b_amax_prob_exact", 64'(argmax_prob), 64'h8000_0000);

    // 4: four stall cycles on beat 3
    fill(4096, -2048);
    mem_r[9] = 12000;
    push_expected();
    pulse_start();
    wait_rd(3, ok);
    check("t4_found_rd3", ok, 1'b1);
    out_ready = 1'b0;
    wait_valid(ok);
    check("t4_found_valid3", ok, 1'b1);
    check("t4_stall_idx", 64'(out_idx), 64'd3);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("t4_done_cycle", 3 * DIM + 1 + 4);
    check_results("t4");

    // 5: start during an active scan is ignored
    fill(1000, 3000);
    mem_i[12] = -20000;
    push_expected();
    pulse_start();
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("t5_busy_mid", busy, 1'b1);
    wait_done("t5_done_cycle", 3 * DIM + 1);
    check_results("t5");

    // 5b: fresh scan after done recomputes from zero
    fill(0, 0);
    mem_r[2] = 8192; mem_i[11] = 8192;
    push_expected();
    pulse_start();
    wait_done("t5b_done_cycle", 3 * DIM + 1);
    check_results("t5b");
    check("t5b_amax_idx_tie", 64'(argmax_idx), 64'd2);

    // 6: reset while beat 7 is pending
    fill(4096, 0);
    push_expected();
    pulse_start();
    wait_rd(7, ok);
    check("t6_found_rd7", ok, 1'b1);
    out_ready = 1'b0;
    wait_valid(ok);
    check("t6_found_valid7", ok, 1'b1);
    check("t6_pending_idx", 64'(out_idx), 64'd7);
    #1 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_idle_valid", out_valid, 1'b0);
      check("t6_idle_busy", busy, 1'b0);
    end

    // Clean scan after the aborted one
    fill(0, 0);
    mem_r[0] = 16384;
    push_expected();
    pulse_start();
    wait_done("t7_done_cycle", 3 * DIM + 1);
    check_results("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
